// File: rtl/adc_stream_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : adc_stream_unpacker
// Purpose  : AXI-Stream slave that buffers 32-bit ADC trigger words in a
//            small FIFO, splits each word into sign-extended channel samples,
//            delimits series into packets and keeps framing statistics.
//            Word layout: [31:30] flag, [29:15] channel A, [14:0] channel B.
//            Flag 00 above trigger, 10 below trigger, 11 last word, 01 illegal.
// Ports    : aclk/areset           clock, asynchronous active-high reset
//            s_axis_*              input stream (tdata, tvalid, tlast, tready)
//            m_valid/m_ready       decoded sample handshake
//            m_sample_a/b          channel samples, 16-bit sign-extended
//            m_below_trig, m_last  flag bit 31, end of packet
//            m_index               sample position in packet (saturating)
//            clr_stats             synchronous clear of counters and errors
//            pkt_count, last_pkt_len, words_rcvd   statistics (wrapping)
//            flag_err, tlast_err, len_err          sticky framing errors
//            fifo_level            words held, including the output register
//            last_pkt_peak         (ADC_UNPACK_PEAK_EN only) max |A|+|B|
// Options  : define ADC_UNPACK_PEAK_EN to add the packet peak tracker.
// Revision : 1.0 - initial release
// ============================================================================
module adc_stream_unpacker #(
  parameter int FIFO_AW      = 4,
  parameter int MAX_LEN_LOG2 = 16
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [31:0]        s_axis_tdata,
  input  logic               s_axis_tvalid,
  input  logic               s_axis_tlast,
  output logic               s_axis_tready,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [15:0]        m_sample_a,
  output logic [15:0]        m_sample_b,
  output logic               m_below_trig,
  output logic               m_last,
  output logic [15:0]        m_index,
  input  logic               clr_stats,
  output logic [31:0]        pkt_count,
  output logic [31:0]        last_pkt_len,
  output logic [31:0]        words_rcvd,
  output logic               flag_err,
  output logic               tlast_err,
  output logic               len_err,
`ifdef ADC_UNPACK_PEAK_EN
  output logic [15:0]        last_pkt_peak,
`endif
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int                 DEPTH      = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL_LEVEL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LVL_ONE    = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
  localparam logic [31:0]        LEN_BOUND  = 32'd1 << MAX_LEN_LOG2;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  // Storage: {tlast, tdata}. The head word is copied into the output
  // register, so the total occupancy is storage count plus output valid.
  logic [32:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               ready_q, ready_d;

  logic               out_valid_q, out_valid_d;
  logic [15:0]        out_a_q, out_a_d;
  logic [15:0]        out_b_q, out_b_d;
  logic               out_below_q, out_below_d;
  logic               out_last_q, out_last_d;

  state_t             state_q, state_d;
  logic [31:0]        pos_q, pos_d;
  logic [31:0]        pkt_count_q, pkt_count_d;
  logic [31:0]        last_pkt_len_q, last_pkt_len_d;
  logic [31:0]        words_rcvd_q, words_rcvd_d;
  logic               flag_err_q, flag_err_d;
  logic               tlast_err_q, tlast_err_d;
  logic               len_err_q, len_err_d;

  logic               wr_en;
  logic               pop_en;
  logic               load_en;
  logic [32:0]        head;
  logic [1:0]         in_flag;

  // --------------------------------------------------------------------------
  // FIFO and output register
  // --------------------------------------------------------------------------
  always_comb begin
    // tready is registered, so a full FIFO never accepts even while popping.
    wr_en   = s_axis_tvalid & ready_q;
    pop_en  = out_valid_q & m_ready;
    // Refill the output register whenever it is empty or being drained.
    load_en = (cnt_q != '0) & (~out_valid_q | pop_en);
    head    = mem_q[rd_ptr_q];
    in_flag = s_axis_tdata[31:30];

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_below_d = out_below_q;
    out_last_d  = out_last_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      cnt_d    = cnt_d + LVL_ONE;
    end

    if (load_en) begin
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      cnt_d       = cnt_d - LVL_ONE;
      out_valid_d = 1'b1;
      out_a_d     = {head[29], head[29:15]};
      out_b_d     = {head[14], head[14:0]};
      out_below_d = head[31];
      out_last_d  = head[32] | (head[31:30] == 2'b11);
    end else if (pop_en) begin
      out_valid_d = 1'b0;
    end

    level_d = cnt_d + {{FIFO_AW{1'b0}}, out_valid_d};
    ready_d = (level_d < FULL_LEVEL);
  end

  // --------------------------------------------------------------------------
  // Packet FSM and statistics
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    pos_d          = pos_q;
    pkt_count_d    = pkt_count_q;
    last_pkt_len_d = last_pkt_len_q;
    words_rcvd_d   = words_rcvd_q;
    flag_err_d     = flag_err_q;
    tlast_err_d    = tlast_err_q;
    len_err_d      = len_err_q;

    if (pop_en) begin
      if (out_last_q) begin
        state_d        = IDLE;
        pos_d          = '0;
        pkt_count_d    = pkt_count_q + 32'd1;
        last_pkt_len_d = (state_q == IDLE) ? 32'd1 : pos_q + 32'd1;
      end else begin
        state_d = IN_PKT;
        if (pos_q != '1) begin
          pos_d = pos_q + 32'd1;
        end
        // The packet has now grown past its bound; it stays open.
        if (pos_q + 32'd1 == LEN_BOUND) begin
          len_err_d = 1'b1;
        end
      end
    end

    if (wr_en) begin
      words_rcvd_d = words_rcvd_q + 32'd1;
      if (in_flag == 2'b01) begin
        flag_err_d = 1'b1;
      end
      if (s_axis_tlast ^ (in_flag == 2'b11)) begin
        tlast_err_d = 1'b1;
      end
    end

    // Clear has priority over a coincident completion or write.
    if (clr_stats) begin
      pkt_count_d    = '0;
      last_pkt_len_d = '0;
      words_rcvd_d   = '0;
      flag_err_d     = 1'b0;
      tlast_err_d    = 1'b0;
      len_err_d      = 1'b0;
    end
  end

`ifdef ADC_UNPACK_PEAK_EN
  logic [15:0] peak_acc_q, peak_acc_d;
  logic [15:0] peak_q, peak_d;
  logic [15:0] mag;

  function automatic logic [15:0] abs16(input logic [15:0] v);
    return v[15] ? (~v + 16'd1) : v;
  endfunction

  // Tracks the sample leaving the output register, so the m_* path is untouched.
  always_comb begin
    mag        = abs16(out_a_q) + abs16(out_b_q);
    peak_acc_d = peak_acc_q;
    peak_d     = peak_q;
    if (pop_en) begin
      if (out_last_q) begin
        peak_d     = (mag > peak_acc_q) ? mag : peak_acc_q;
        peak_acc_d = '0;
      end else if (mag > peak_acc_q) begin
        peak_acc_d = mag;
      end
    end
    if (clr_stats) begin
      peak_d = '0;
    end
  end

  assign last_pkt_peak = peak_q;
`endif

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      level_q        <= '0;
      ready_q        <= 1'b0;
      out_valid_q    <= 1'b0;
      out_a_q        <= '0;
      out_b_q        <= '0;
      out_below_q    <= 1'b0;
      out_last_q     <= 1'b0;
      state_q        <= IDLE;
      pos_q          <= '0;
      pkt_count_q    <= '0;
      last_pkt_len_q <= '0;
      words_rcvd_q   <= '0;
      flag_err_q     <= 1'b0;
      tlast_err_q    <= 1'b0;
      len_err_q      <= 1'b0;
`ifdef ADC_UNPACK_PEAK_EN
      peak_acc_q     <= '0;
      peak_q         <= '0;
`endif
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
      level_q        <= level_d;
      ready_q        <= ready_d;
      out_valid_q    <= out_valid_d;
      out_a_q        <= out_a_d;
      out_b_q        <= out_b_d;
      out_below_q    <= out_below_d;
      out_last_q     <= out_last_d;
      state_q        <= state_d;
      pos_q          <= pos_d;
      pkt_count_q    <= pkt_count_d;
      last_pkt_len_q <= last_pkt_len_d;
      words_rcvd_q   <= words_rcvd_d;
      flag_err_q     <= flag_err_d;
      tlast_err_q    <= tlast_err_d;
      len_err_q      <= len_err_d;
`ifdef ADC_UNPACK_PEAK_EN
      peak_acc_q     <= peak_acc_d;
      peak_q         <= peak_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign s_axis_tready = ready_q;
  assign m_valid       = out_valid_q;
  assign m_sample_a    = out_a_q;
  assign m_sample_b    = out_b_q;
  assign m_below_trig  = out_below_q;
  assign m_last        = out_last_q;
  assign m_index       = (pos_q[31:16] != '0) ? 16'hFFFF : pos_q[15:0];
  assign pkt_count     = pkt_count_q;
  assign last_pkt_len  = last_pkt_len_q;
  assign words_rcvd    = words_rcvd_q;
  assign flag_err      = flag_err_q;
  assign tlast_err     = tlast_err_q;
  assign len_err       = len_err_q;
  assign fifo_level    = level_q;

endmodule
`default_nettype wire

// File: doc/adc_stream_unpacker.md
Name: adc_stream_unpacker

Overview:
- AXI-Stream slave that consumes the 32-bit ADC trigger stream and splits it back into per-sample fields.
- Word format: bits[31:30] flag, bits[29:15] channel A, bits[14:0] channel B. Flag 00 = above trigger, 10 = below trigger, 11 = last word of series, 01 = illegal.
- Buffers words in a small FIFO with backpressure, delimits series (packets), and checks framing.
- Sits between the ADC trigger core and downstream DSP/DMA logic; exposes packet statistics to the register bank.

Parameters:
- FIFO_AW, 4, log2 of FIFO depth in words (depth 16).
- MAX_LEN_LOG2, 16, packet length bound; packets longer than 2^MAX_LEN_LOG2 words raise len_err.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  32  stream word.
- s_axis_tvalid  in  1  word valid.
- s_axis_tlast  in  1  end of series.
- s_axis_tready  out  1  FIFO not full.
- m_valid  out  1  decoded sample valid.
- m_ready  in  1  downstream accepts the sample.
- m_sample_a  out  16  channel A, 15-bit field sign-extended.
- m_sample_b  out  16  channel B, sign-extended.
- m_below_trig  out  1  flag bit31.
- m_last  out  1  last sample of packet.
- m_index  out  16  position of the sample within its packet, from 0.
- clr_stats  in  1  synchronous clear of statistics and error flags.
- pkt_count  out  32  completed packets.
- last_pkt_len  out  32  word count of the last completed packet.
- words_rcvd  out  32  total accepted input words.
- flag_err  out  1  sticky: flag 01 seen.
- tlast_err  out  1  sticky: tlast does not match (flag==11).
- len_err  out  1  sticky: packet exceeded its bound.
- fifo_level  out  FIFO_AW+1  current occupancy.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE. s_axis_tready rises the first cycle after reset deasserts.
- Input handshake:
  - A word is written when s_axis_tvalid && s_axis_tready.
  - s_axis_tready = (fifo_level < 2^FIFO_AW).
  - A simultaneous read and write when full is not allowed: tready stays 0 when full.
  - A simultaneous read and write at any other level keeps fifo_level unchanged.
- Output handshake:
  - First-word fall-through with registered output. A word written at edge N is visible on m_* after edge N+1 at the earliest.
  - m_* fields are held stable while m_valid && !m_ready.
  - The sample pops on m_valid && m_ready; the next word is presented the following cycle, giving full throughput with no bubbles.
- FSM (advances on output handshake only):
  - IDLE: an accepted sample with m_last=0 goes to IN_PKT with index 1. m_last=1 (single-word packet) stays in IDLE, with pkt_count+1 and last_pkt_len=1.
  - IN_PKT: each accepted sample increments the index. m_last=1 goes to IDLE with pkt_count+1 and last_pkt_len=index+1, and the index resets to 0.
- m_last = stored tlast OR stored flag==11. An implicit end from either source closes the packet.
- m_index saturates at 0xFFFF.
- len_err sets when the index reaches 2^MAX_LEN_LOG2 without a last; the packet stays open.
- Errors are evaluated on the input write:
  - flag 01 sets flag_err; the word is still passed through, with m_below_trig=0.
  - tlast XOR (flag==11) sets tlast_err.
- words_rcvd increments on every input write. All 32-bit counters wrap.
- clr_stats zeroes pkt_count, last_pkt_len, words_rcvd and all error flags. It does not affect the FIFO, the FSM or m_index.
- If clr_stats coincides with a packet completion, clear wins: pkt_count=0 and last_pkt_len=0.
- Reset mid-packet: FIFO contents are discarded and the FSM returns to IDLE immediately (asynchronous reset).

Optional Feature:
- Macro: ADC_UNPACK_PEAK_EN.
- Enabled: adds output last_pkt_peak (16 bits) = max over the packet of |A|+|B|, computed with 16-bit unsigned arithmetic.
  - Latched at packet completion; cleared by clr_stats and by reset.
  - Adds no latency to the m_* path.
- Disabled: the port and its logic are absent.

Test Plan:
- Four words 0x00004001, 0x80004001, 0x80004001, 0xC0004001 (last with tlast), m_ready=1 -> four samples with A=0x0000, B=0x4001 sign-extended to 0xC001, m_index 0..3, m_last on the 4th, pkt_count=1, last_pkt_len=4, no errors.
- m_ready=0 while 20 words are offered -> s_axis_tready drops after 16 accepted, fifo_level=16; release m_ready -> all 20 words delivered in order, none lost or duplicated.
- Word 0x40000000 with tlast=0 -> flag_err=1, tlast_err=0. Word 0xC0000000 with tlast=0 -> tlast_err=1, and the packet still closes.
- MAX_LEN_LOG2=3, nine words without last -> len_err=1 on the 9th sample, FSM remains IN_PKT.
- clr_stats pulsed in the same cycle as a last-sample handshake -> pkt_count=0, last_pkt_len=0 afterward.
- areset asserted with 5 words buffered and a packet open -> the next cycle has m_valid=0, fifo_level=0, and the next packet starts at m_index=0.
